jt12_regwr: RTL and testbench

JT12_REGWR -- requirements
Module: jt12_regwr

---
 rtl/jt12_regwr.sv | 245 ++++++++++++++++++++++++
 tb/tb_jt12_regwr.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/jt12_regwr.sv
// YM2612/YM2203 CPU register-write front end: address latch, write decode, slot-synchronised update strobes.
// Optional CH3 special-mode registers are built in when JT12_CH3FX_EN is defined.
module jt12_regwr #(
  parameter int num_ch = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        wr,
  input  logic        a0,
  input  logic        a1,
  input  logic [7:0]  din,
  input  logic        zero,
  output logic        busy,
  output logic [2:0]  ch,
  output logic [1:0]  op,
  output logic [7:0]  dout,
  output logic        up_keyon,
  output logic        up_dt1,
  output logic        up_tl,
  output logic        up_ks_ar,
  output logic        up_amen_dr,
  output logic        up_sr,
  output logic        up_sl_rr,
  output logic        up_ssgeg,
  output logic        up_fnumlo,
  output logic        up_alg,
  output logic        up_pms,
  output logic [5:0]  latch_fnum,
  output logic        effect,
  output logic [10:0] fnum_ch3op1,
  output logic [10:0] fnum_ch3op2,
  output logic [10:0] fnum_ch3op3,
  output logic [2:0]  block_ch3op1,
  output logic [2:0]  block_ch3op2,
  output logic [2:0]  block_ch3op3
);

  localparam logic PART_EN = (num_ch == 6);

  // Strobe bit order: keyon, dt1, tl, ks_ar, amen_dr, sr, sl_rr, ssgeg, fnumlo, alg, pms
  function automatic logic [10:0] decode_strobe(input logic [8:0] addr);
    logic [10:0] s;
    s = 11'd0;
    if (addr[1:0] != 2'd3) begin
      case (addr[7:4])
        4'h3: s[1] = 1'b1;
        4'h4: s[2] = 1'b1;
        4'h5: s[3] = 1'b1;
        4'h6: s[4] = 1'b1;
        4'h7: s[5] = 1'b1;
        4'h8: s[6] = 1'b1;
        4'h9: s[7] = 1'b1;
        4'hA: s[8] = (addr[3:2] == 2'd0);
        4'hB: begin
          s[9]  = (addr[3:2] == 2'd0);
          s[10] = (addr[3:2] == 2'd1);
        end
        default: s = 11'd0;
      endcase
    end else begin
      s = 11'd0;
    end
    if (addr == 9'h028) begin
      s[0] = 1'b1;
    end else begin
      s[0] = s[0];
    end
    return s;
  endfunction

  logic [8:0]  addr_q, addr_d;
  logic [10:0] up_q, up_d;
  logic        busy_q, busy_d;
  logic        zcnt_q, zcnt_d;
  logic [7:0]  dout_q, dout_d;
  logic [2:0]  ch_q, ch_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  latch_q, latch_d;
  logic        part_s;
  logic        data_wr_s;
  logic [10:0] strobe_s;

  assign part_s    = a1 & PART_EN;
  assign data_wr_s = wr & a0 & ~busy_q;
  assign strobe_s  = decode_strobe(addr_q);

  // Next-state for address latch, pending-write tracker and latched outputs
  always_comb begin
    addr_d  = addr_q;
    up_d    = up_q;
    busy_d  = busy_q;
    zcnt_d  = zcnt_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    op_d    = op_q;
    latch_d = latch_q;
    if (wr && !a0) begin
      addr_d = {part_s, din};
    end else begin
      addr_d = addr_q;
    end
    if (busy_q) begin
      // Acceptance clk never gets here, so a zero pulse in that clk is not counted
      if (clk_en && zero) begin
        if (zcnt_q) begin
          up_d   = 11'd0;
          busy_d = 1'b0;
          zcnt_d = 1'b0;
        end else begin
          zcnt_d = 1'b1;
        end
      end else begin
        zcnt_d = zcnt_q;
      end
    end else if (data_wr_s) begin
      if (|strobe_s) begin
        up_d   = strobe_s;
        busy_d = 1'b1;
        zcnt_d = 1'b0;
        dout_d = din;
        ch_d   = {addr_q[8], addr_q[1:0]};
        op_d   = addr_q[3:2];
      end else begin
        up_d = up_q;
      end
      if (addr_q[7:2] == 6'b1010_01 && addr_q[1:0] != 2'd3) begin
        latch_d = din[5:0];
      end else begin
        latch_d = latch_q;
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 9'd0;
      up_q    <= 11'd0;
      busy_q  <= 1'b0;
      zcnt_q  <= 1'b0;
      dout_q  <= 8'd0;
      ch_q    <= 3'd0;
      op_q    <= 2'd0;
      latch_q <= 6'd0;
    end else begin
      addr_q  <= addr_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      zcnt_q  <= zcnt_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      latch_q <= latch_d;
    end
  end

  assign busy       = busy_q;
  assign ch         = ch_q;
  assign op         = op_q;
  assign dout       = dout_q;
  assign latch_fnum = latch_q;
  assign up_keyon   = up_q[0];
  assign up_dt1     = up_q[1];
  assign up_tl      = up_q[2];
  assign up_ks_ar   = up_q[3];
  assign up_amen_dr = up_q[4];
  assign up_sr      = up_q[5];
  assign up_sl_rr   = up_q[6];
  assign up_ssgeg   = up_q[7];
  assign up_fnumlo  = up_q[8];
  assign up_alg     = up_q[9];
  assign up_pms     = up_q[10];

`ifdef JT12_CH3FX_EN
  logic        eff_q, eff_d;
  logic [10:0] fn1_q, fn1_d, fn2_q, fn2_d, fn3_q, fn3_d;
  logic [2:0]  bl1_q, bl1_d, bl2_q, bl2_d, bl3_q, bl3_d;

  // CH3 special-mode register decode (part 0 only)
  always_comb begin
    eff_d = eff_q;
    fn1_d = fn1_q;
    fn2_d = fn2_q;
    fn3_d = fn3_q;
    bl1_d = bl1_q;
    bl2_d = bl2_q;
    bl3_d = bl3_q;
    if (data_wr_s && !addr_q[8]) begin
      case (addr_q[7:0])
        8'h27: eff_d = din[6];
        8'hA9: fn1_d = {fn1_q[10:8], din};
        8'hAA: fn2_d = {fn2_q[10:8], din};
        8'hA8: fn3_d = {fn3_q[10:8], din};
        8'hAD: begin bl1_d = din[5:3]; fn1_d = {din[2:0], fn1_q[7:0]}; end
        8'hAE: begin bl2_d = din[5:3]; fn2_d = {din[2:0], fn2_q[7:0]}; end
        8'hAC: begin bl3_d = din[5:3]; fn3_d = {din[2:0], fn3_q[7:0]}; end
        default: eff_d = eff_q;
      endcase
    end else begin
      eff_d = eff_q;
    end
  end

  // CH3 special-mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_q <= 1'b0;
      fn1_q <= 11'd0;
      fn2_q <= 11'd0;
      fn3_q <= 11'd0;
      bl1_q <= 3'd0;
      bl2_q <= 3'd0;
      bl3_q <= 3'd0;
    end else begin
      eff_q <= eff_d;
      fn1_q <= fn1_d;
      fn2_q <= fn2_d;
      fn3_q <= fn3_d;
      bl1_q <= bl1_d;
      bl2_q <= bl2_d;
      bl3_q <= bl3_d;
    end
  end

  assign effect       = eff_q;
  assign fnum_ch3op1  = fn1_q;
  assign fnum_ch3op2  = fn2_q;
  assign fnum_ch3op3  = fn3_q;
  assign block_ch3op1 = bl1_q;
  assign block_ch3op2 = bl2_q;
  assign block_ch3op3 = bl3_q;
`else
  assign effect       = 1'b0;
  assign fnum_ch3op1  = 11'd0;
  assign fnum_ch3op2  = 11'd0;
  assign fnum_ch3op3  = 11'd0;
  assign block_ch3op1 = 3'd0;
  assign block_ch3op2 = 3'd0;
  assign block_ch3op3 = 3'd0;
`endif

endmodule

// File: tb/tb_jt12_regwr.sv
// Directed self-checking bench for jt12_regwr; CH3 expectations follow JT12_CH3FX_EN.
module tb_jt12_regwr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        wr = 1'b0;
  logic        a0 = 1'b0;
  logic        a1 = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        zero = 1'b0;
  logic        busy;
  logic [2:0]  ch;
  logic [1:0]  op;
  logic [7:0]  dout;
  logic        up_keyon, up_dt1, up_tl, up_ks_ar, up_amen_dr, up_sr;
  logic        up_sl_rr, up_ssgeg, up_fnumlo, up_alg, up_pms;
  logic [5:0]  latch_fnum;
  logic        effect;
  logic [10:0] fnum_ch3op1, fnum_ch3op2, fnum_ch3op3;
  logic [2:0]  block_ch3op1, block_ch3op2, block_ch3op3;
  logic [10:0] up_v;
  int checks = 0;
  int errors = 0;

  jt12_regwr #(.num_ch(6)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr(wr), .a0(a0), .a1(a1),
    .din(din), .zero(zero), .busy(busy), .ch(ch), .op(op), .dout(dout),
    .up_keyon(up_keyon), .up_dt1(up_dt1), .up_tl(up_tl), .up_ks_ar(up_ks_ar),
    .up_amen_dr(up_amen_dr), .up_sr(up_sr), .up_sl_rr(up_sl_rr),
    .up_ssgeg(up_ssgeg), .up_fnumlo(up_fnumlo), .up_alg(up_alg), .up_pms(up_pms),
    .latch_fnum(latch_fnum), .effect(effect),
    .fnum_ch3op1(fnum_ch3op1), .fnum_ch3op2(fnum_ch3op2), .fnum_ch3op3(fnum_ch3op3),
    .block_ch3op1(block_ch3op1), .block_ch3op2(block_ch3op2), .block_ch3op3(block_ch3op3)
  );

  always #5 clk = ~clk;

  assign up_v = {up_pms, up_alg, up_fnumlo, up_ssgeg, up_sl_rr, up_sr,
                 up_amen_dr, up_ks_ar, up_tl, up_dt1, up_keyon};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-clk write access; inputs change on negedge, outputs are sampled on the next negedge
  task automatic cpu_wr(input logic p, input logic isdata, input logic [7:0] d, input logic z);
    @(negedge clk);
    wr = 1'b1; a0 = isdata; a1 = p; din = d; zero = z;
    @(negedge clk);
    wr = 1'b0; zero = 1'b0;
  endtask

  task automatic zpulse(input logic en);
    @(negedge clk);
    zero = 1'b1; clk_en = en;
    @(negedge clk);
    zero = 1'b0; clk_en = 1'b1;
  endtask

  task automatic check_idle_all(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_up"}, {21'd0, up_v}, 32'd0);
    check({tag, "_dout_ch_op"}, {19'd0, dout, ch, op}, 32'd0);
    check({tag, "_latch_eff"}, {25'd0, latch_fnum, effect}, 32'd0);
    check({tag, "_ch3"}, {1'b0, fnum_ch3op1, fnum_ch3op2, block_ch3op1, block_ch3op2, block_ch3op3},
          32'd0);
    check({tag, "_ch3op3"}, {21'd0, fnum_ch3op3}, 32'd0);
  endtask

  initial begin
    logic        exp_eff;
    logic [10:0] exp_fn1;
    logic [2:0]  exp_bl1;
`ifdef JT12_CH3FX_EN
    exp_eff = 1'b1; exp_fn1 = 11'h312; exp_bl1 = 3'd5;
`else
    exp_eff = 1'b0; exp_fn1 = 11'h000; exp_bl1 = 3'd0;
`endif
    #12;
    check_idle_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Operator write, part 1: TL row, slot 2 -> ch 6, op 0
    cpu_wr(1'b1, 1'b0, 8'h42, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h7F, 1'b0);
    check("tl_up", {21'd0, up_v}, 32'h004);
    check("tl_ch", {29'd0, ch}, 32'd6);
    check("tl_op", {30'd0, op}, 32'd0);
    check("tl_dout", {24'd0, dout}, 32'h7F);
    check("tl_busy", {31'd0, busy}, 32'd1);

    // Data write while busy is dropped; address still accepted
    cpu_wr(1'b0, 1'b0, 8'h30, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h55, 1'b0);
    check("drop_dout", {24'd0, dout}, 32'h7F);
    check("drop_up", {21'd0, up_v}, 32'h004);

    // zero without clk_en does not count; first qualified pulse keeps hold
    zpulse(1'b0);
    check("noen_busy", {31'd0, busy}, 32'd1);
    zpulse(1'b1);
    check("z1_busy", {31'd0, busy}, 32'd1);
    check("z1_up", {31'd0, up_tl}, 32'd1);
    zpulse(1'b1);
    check("z2_busy", {31'd0, busy}, 32'd0);
    check("z2_up", {21'd0, up_v}, 32'd0);
    check("z2_dout_hold", {24'd0, dout}, 32'h7F);

    // Hi byte latch then lo byte strobe
    cpu_wr(1'b0, 1'b0, 8'hA4, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h22, 1'b0);
    check("latch_val", {26'd0, latch_fnum}, 32'h22);
    check("latch_busy", {31'd0, busy}, 32'd0);
    cpu_wr(1'b0, 1'b0, 8'hA0, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h69, 1'b0);
    check("fnlo_up", {21'd0, up_v}, 32'h100);
    check("fnlo_dout", {24'd0, dout}, 32'h69);
    check("fnlo_latch_keep", {26'd0, latch_fnum}, 32'h22);
    zpulse(1'b1);
    zpulse(1'b1);
    check("fnlo_clr", {30'd0, busy, up_fnumlo}, 32'd0);

    // Zero pulse in the acceptance clk is ignored: PMS part 1 slot 0 -> ch 4
    cpu_wr(1'b1, 1'b0, 8'hB4, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'hC0, 1'b1);
    check("pms_up", {21'd0, up_v}, 32'h400);
    check("pms_ch_op", {27'd0, ch, op}, {27'd0, 3'd4, 2'd1});
    zpulse(1'b1);
    check("acc_zero_busy", {31'd0, busy}, 32'd1);
    zpulse(1'b1);
    check("acc_zero_clr", {31'd0, busy}, 32'd0);

    // Slot 3 ignored, unmapped ignored, keyon only on part 0
    cpu_wr(1'b0, 1'b0, 8'h33, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h11, 1'b0);
    check("slot3_ign", {20'd0, busy, up_v}, 32'd0);
    cpu_wr(1'b0, 1'b0, 8'h20, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h11, 1'b0);
    check("unmapped_ign", {20'd0, busy, up_v}, 32'd0);
    cpu_wr(1'b1, 1'b0, 8'h28, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'hF2, 1'b0);
    check("keyon_p1_ign", {20'd0, busy, up_v}, 32'd0);
    cpu_wr(1'b0, 1'b0, 8'h28, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'hF2, 1'b0);
    check("keyon_up", {21'd0, up_v}, 32'h001);
    check("keyon_dout", {24'd0, dout}, 32'hF2);
    zpulse(1'b1);
    zpulse(1'b1);
    check("keyon_clr", {31'd0, busy}, 32'd0);

    // CH3 special mode
    cpu_wr(1'b0, 1'b0, 8'h27, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h40, 1'b0);
    cpu_wr(1'b0, 1'b0, 8'hA9, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h12, 1'b0);
    cpu_wr(1'b0, 1'b0, 8'hAD, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h2B, 1'b0);
    check("ch3_effect", {31'd0, effect}, {31'd0, exp_eff});
    check("ch3_fnum1", {21'd0, fnum_ch3op1}, {21'd0, exp_fn1});
    check("ch3_block1", {29'd0, block_ch3op1}, {29'd0, exp_bl1});
    check("ch3_nobusy", {20'd0, busy, up_v}, 32'd0);

    // Asynchronous reset mid-pending
    cpu_wr(1'b0, 1'b0, 8'h52, 1'b0);
    cpu_wr(1'b0, 1'b1, 8'h1F, 1'b0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cpu_wr(1'b0, 1'b1, 8'h99, 1'b0);
    check("post_rst_idle", {20'd0, busy, up_v}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
